cpu_main_fsm: RTL and testbench
===============================

# cpu_main_fsm

Multi-cycle control unit for the RISC-V core. It decodes the fetched instruction, steps the datapath through fetch/decode/execute/memory/writeback states, and drives the datapath mux selects, write strobes and the 3-bit ALU operation select. It sits directly upstream of the ALU and consumes the ALU's `z_flag` for branch resolution. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

## Interface
- `ALU_SEL_W`, 3: ALU op select width; must match the ALU `op_sel`.
- `clk` in 1: core clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: instruction register bits [6:0].
- `funct3` in 3: instruction register bits [14:12].
- `funct7b5` in 1: instruction register bit 30.
- `z_flag` in 1: ALU zero flag, combinational in the same cycle.
- `mem_rdy` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC register load enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALU result register.
- `ir_write` out 1: instruction register / old-PC load enable.
- `mem_write` out 1: data memory write request.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result mux; 00 = ALU out register, 01 = memory data, 10 = ALU result direct.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src` out 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_op_sel` out 3: ALU operation, drives ALU `op_sel`.
- `illegal_instr` out 1: one-cycle pulse in DECODE for an unsupported instruction.

## Operation
- Moore FSM. Outputs decode from state, except where noted. Unlisted strobes are 0 and unlisted selects are 00.
- Supported opcodes:
  - lw 0000011, sw 0100011
  - R-type 0110011, I-ALU 0010011
  - beq 1100011, jal 1101111
- FETCH:
  - `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10.
  - `ir_write`=`pc_write`=`mem_rdy`.
  - Stay in FETCH while `!mem_rdy`; go to DECODE on `mem_rdy`.
- DECODE:
  - `alu_src_a`=01, `alu_src_b`=01, ADD (branch target); `imm_src` from opcode.
  - Next state: lw/sw → MEMADR; R → EXECUTER; I-ALU → EXECUTEI; beq → BEQ; jal → JAL.
  - Any other opcode → FETCH with `illegal_instr`=1.
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, ADD. lw → MEMREAD; sw → MEMWRITE.
- MEMREAD: `adr_src`=1, `result_src`=00. Wait for `mem_rdy`, then → MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
- MEMWRITE: `adr_src`=1, `result_src`=00, `mem_write`=1 held until `mem_rdy`, then → FETCH.
- EXECUTER: `alu_src_a`=10, `alu_src_b`=00, funct-decoded op → ALUWB.
- EXECUTEI: `alu_src_a`=10, `alu_src_b`=01, funct-decoded op → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
- BEQ:
  - `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00.
  - `pc_write`=`z_flag` (Mealy term) → FETCH.
- JAL: `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00, `pc_write`=1 → ALUWB.
- Funct decode:
  - funct3 000: SUB if R-type and `funct7b5`=1, else ADD (I-ALU ignores `funct7b5`).
  - funct3 010 → SLT; 110 → OR; 111 → AND.
  - Any other funct3 on R/I-ALU: `illegal_instr` in DECODE, then → FETCH.
- ALU encodings: ADD 000, SUB 001, AND 010, OR 011, SLT 101.

## Timing
- Reset:
  - While `rst`=1, all outputs are 0.
  - State = FETCH after the first rising edge with `rst`=1.
  - First fetch strobes appear in the cycle after `rst` deasserts, given `mem_rdy`=1.
- Reset mid-instruction aborts it. No write strobe is asserted in the reset cycle or after it.
- Latency with `mem_rdy` always 1:
  - lw 5 cycles; sw 4; R/I-ALU 4; beq 3; jal 4.
  - Each wait cycle on `mem_rdy` adds 1 (FETCH, MEMREAD, MEMWRITE).
- `mem_rdy` is sampled only in FETCH, MEMREAD and MEMWRITE; it is ignored elsewhere.
- `illegal_instr` is high exactly one cycle.
- The FSM never deadlocks on a legal opcode. An illegal opcode costs 2 cycles (FETCH + DECODE).

## Structure
- `pkg_cpu_typedefs` holds:
  - the ALU op encodings (shared with the ALU);
  - the FSM state enum;
  - the opcode constants;
  - the `result_src`, `alu_src_a`, `alu_src_b` and `imm_src` encodings.
- Sub-module `cpu_alu_decoder`: purely combinational; (alu_op class, funct3, funct7b5, opcode bit 5) → `alu_op_sel` plus an unsupported flag.
- `cpu_main_fsm` holds only the state register, next-state logic and output decode.

## Test plan
- Reset held 3 cycles then released, `mem_rdy`=1 → all outputs 0 during reset; cycle 1 after release shows FETCH outputs with `ir_write`=`pc_write`=1.
- `add` (0x00B50533) then `sub` (0x40B50533) → EXECUTER `alu_op_sel`=000 then 001; `reg_write` in ALUWB; 4 cycles each.
- lw with `mem_rdy` low 2 cycles in MEMREAD → MEMREAD held 3 cycles, `adr_src`=1; MEMWB `result_src`=01, `reg_write`=1; total 7 cycles.
- beq with `z_flag`=1 then a second beq with `z_flag`=0 → `pc_write`=1 for the first and 0 for the second, `alu_op_sel`=001 in both.
- Opcode 0x7F, and an R-type with funct3=001 → `illegal_instr` pulses 1 cycle in DECODE, no write strobes, back to FETCH.
- `rst` asserted during MEMWRITE with `mem_rdy`=0 → `mem_write` drops to 0 in the reset cycle; FSM restarts in FETCH.

Source files
------------

// File: rtl/pkg_cpu_typedefs.sv
// rtl/pkg_cpu_typedefs.sv - shared ALU op, FSM state, opcode and datapath select encodings
package pkg_cpu_typedefs;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  // Operation class handed to the ALU decoder; FUNCT defers to funct3/funct7b5.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/cpu_alu_decoder.sv
// rtl/cpu_alu_decoder.sv - combinational ALU op select from op class and funct fields
module cpu_alu_decoder
  import pkg_cpu_typedefs::*;
(
  input  logic [1:0] alu_class,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_op_sel,
  output logic       unsupported
);

  logic [2:0] funct_op;

  // unsupported reflects funct3 alone so DECODE can flag it before EXECUTE.
  always_comb begin
    funct_op    = ALU_ADD;
    unsupported = 1'b0;
    case (funct3)
      3'b000:  funct_op = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  funct_op = ALU_SLT;
      3'b110:  funct_op = ALU_OR;
      3'b111:  funct_op = ALU_AND;
      default: unsupported = 1'b1;
    endcase
  end

  always_comb begin
    case (alu_class)
      ALUOP_SUB:   alu_op_sel = ALU_SUB;
      ALUOP_FUNCT: alu_op_sel = funct_op;
      default:     alu_op_sel = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_main_fsm.sv
// rtl/cpu_main_fsm.sv - multi-cycle RISC-V control FSM with memory ready handshake
module cpu_main_fsm
  import pkg_cpu_typedefs::*;
#(
  parameter int ALU_SEL_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 z_flag,
  input  logic                 mem_rdy,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [ALU_SEL_W-1:0] alu_op_sel,
  output logic                 illegal_instr
);

  state_t     state_q, state_d;
  logic [1:0] alu_class;
  logic [2:0] dec_op;
  logic       funct_bad;
  logic       is_rtype, is_itype, is_known, decode_illegal;

  cpu_alu_decoder u_alu_dec (
    .alu_class   (alu_class),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (opcode[5]),
    .alu_op_sel  (dec_op),
    .unsupported (funct_bad)
  );

  assign is_rtype = (opcode == OP_R);
  assign is_itype = (opcode == OP_I);
  assign is_known = (opcode == OP_LW) || (opcode == OP_SW) || is_rtype || is_itype ||
                    (opcode == OP_BEQ) || (opcode == OP_JAL);
  assign decode_illegal = !is_known || ((is_rtype || is_itype) && funct_bad);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (decode_illegal)                          state_d = S_FETCH;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (is_rtype)                           state_d = S_EXECUTER;
        else if (is_itype)                           state_d = S_EXECUTEI;
        else if (opcode == OP_BEQ)                   state_d = S_BEQ;
        else                                         state_d = S_JAL;
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECUTER,
      S_EXECUTEI,
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Reset overrides everything so a write in flight is dropped in the reset cycle itself.
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    imm_src       = IMM_I;
    alu_class     = ALUOP_ADD;
    illegal_instr = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURES;
          ir_write   = mem_rdy;
          pc_write   = mem_rdy;
        end
        S_DECODE: begin
          alu_src_a     = SRCA_OLDPC;
          alu_src_b     = SRCB_IMM;
          illegal_instr = decode_illegal;
          if (opcode == OP_SW)       imm_src = IMM_S;
          else if (opcode == OP_BEQ) imm_src = IMM_B;
          else if (opcode == OP_JAL) imm_src = IMM_J;
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMREAD:  adr_src = 1'b1;
        S_MEMWB: begin
          result_src = RES_RDATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECUTER: begin
          alu_src_a = SRCA_RS1;
          alu_class = ALUOP_FUNCT;
        end
        S_EXECUTEI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          alu_class = ALUOP_FUNCT;
        end
        S_ALUWB:    reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = SRCA_RS1;
          alu_class = ALUOP_SUB;
          pc_write  = z_flag;
        end
        S_JAL: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_FOUR;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_op_sel = rst ? '0 : ALU_SEL_W'(dec_op);

endmodule

// File: tb/tb_cpu_main_fsm.sv
// tb/tb_cpu_main_fsm.sv - scoreboard bench for cpu_main_fsm with per-cycle expected outputs
module tb_cpu_main_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       z_flag = 1'b0;
  logic       mem_rdy = 1'b1;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_op_sel;

  cpu_main_fsm #(.ALU_SEL_W(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .z_flag(z_flag), .mem_rdy(mem_rdy), .pc_write(pc_write), .adr_src(adr_src),
    .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_op_sel(alu_op_sel), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef logic [16:0] vec_t;
  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_ILLOP, K_ILLF} kind_t;

  vec_t exp_q[$];
  vec_t act;
  int   vectors = 0;
  int   miscompares = 0;

  // {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, a, b, imm, alu, illegal}
  assign act = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
                alu_src_a, alu_src_b, imm_src, alu_op_sel, illegal_instr};

  function automatic vec_t mk(bit pcw, bit adr, bit irw, bit mw, bit rw, bit [1:0] res,
                              bit [1:0] a, bit [1:0] b, bit [1:0] imm, bit [2:0] alu, bit ill);
    return {pcw, adr, irw, mw, rw, res, a, b, imm, alu, ill};
  endfunction

  function automatic bit [2:0] exp_alu(bit is_r, bit [2:0] f3, bit f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic cyc(input bit r, input bit rdy, input bit z, input vec_t e);
    @(posedge clk);
    #1;
    rst = r;
    mem_rdy = rdy;
    z_flag = z;
    exp_q.push_back(e);
  endtask

  task automatic fetch_decode(input kind_t k, input bit [6:0] op, input bit [2:0] f3,
                              input bit f7, input int fw);
    bit [1:0] imm;
    for (int i = 0; i < fw; i++) cyc(0, 0, rb(), mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    cyc(0, 1, rb(), mk(1,0,1,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    opcode = op;
    funct3 = f3;
    funct7b5 = f7;
    imm = (k == K_SW) ? 2'b01 : (k == K_BEQ) ? 2'b10 : (k == K_JAL) ? 2'b11 : 2'b00;
    cyc(0, rb(), rb(), mk(0,0,0,0,0,2'b00,2'b01,2'b01,imm,3'b000,
                          (k == K_ILLOP || k == K_ILLF)));
  endtask

  task automatic run_instr(input kind_t k, input bit [6:0] op, input bit [2:0] f3, input bit f7,
                           input int fw, input int mw, input bit z);
    fetch_decode(k, op, f3, f7, fw);
    case (k)
      K_LW: begin
        cyc(0, rb(), rb(), mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        for (int i = 0; i < mw; i++) cyc(0, 0, rb(), mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        cyc(0, 1, rb(), mk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        cyc(0, rb(), rb(), mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
      end
      K_SW: begin
        cyc(0, rb(), rb(), mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
        for (int i = 0; i < mw; i++) cyc(0, 0, rb(), mk(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        cyc(0, 1, rb(), mk(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
      end
      K_R, K_I: begin
        cyc(0, rb(), rb(), mk(0,0,0,0,0,2'b00,2'b10,(k == K_R) ? 2'b00 : 2'b01,2'b00,
                              exp_alu(k == K_R, f3, f7),0));
        cyc(0, rb(), rb(), mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
      end
      K_BEQ: cyc(0, rb(), z, mk(z,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0));
      K_JAL: begin
        cyc(0, rb(), rb(), mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0));
        cyc(0, rb(), rb(), mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        vec_t e;
        e = exp_q.pop_front();
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL cycle_outputs vec%0d t=%0t actual=%h required=%h", vectors, $time, act, e);
        end
      end
    end
  end

  initial begin
    bit [6:0] ops[6];
    bit [2:0] good_f3[4];
    bit [2:0] bad_f3[4];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    good_f3 = '{3'b000, 3'b010, 3'b110, 3'b111};
    bad_f3 = '{3'b001, 3'b011, 3'b100, 3'b101};

    for (int i = 0; i < 3; i++) cyc(1, 1, 0, '0);

    run_instr(K_R, 7'b0110011, 3'b000, 1'b0, 0, 0, 0);
    run_instr(K_R, 7'b0110011, 3'b000, 1'b1, 0, 0, 0);
    run_instr(K_LW, 7'b0000011, 3'b010, 1'b0, 0, 2, 0);
    run_instr(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 1);
    run_instr(K_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, 0);
    run_instr(K_ILLOP, 7'h7F, 3'b000, 1'b0, 0, 0, 0);
    run_instr(K_ILLF, 7'b0110011, 3'b001, 1'b0, 0, 0, 0);
    run_instr(K_I, 7'b0010011, 3'b000, 1'b1, 1, 0, 0);
    run_instr(K_JAL, 7'b1101111, 3'b000, 1'b0, 0, 0, 0);
    run_instr(K_SW, 7'b0100011, 3'b010, 1'b0, 0, 1, 0);

    // Reset lands while a store is stalled in MEMWRITE.
    fetch_decode(K_SW, 7'b0100011, 3'b010, 1'b0, 0);
    cyc(0, 0, 0, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    cyc(0, 0, 0, mk(0,1,0,1,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    cyc(1, 0, 0, '0);
    run_instr(K_R, 7'b0110011, 3'b111, 1'b0, 0, 0, 0);

    for (int n = 0; n < 150; n++) begin
      kind_t    k;
      bit [6:0] op;
      bit [2:0] f3;
      k = kind_t'($urandom_range(0, 7));
      f3 = good_f3[$urandom_range(0, 3)];
      case (k)
        K_ILLOP: begin
          op = 7'($urandom);
          while (op inside {ops}) op = 7'($urandom);
        end
        K_ILLF: begin
          op = rb() ? 7'b0110011 : 7'b0010011;
          f3 = bad_f3[$urandom_range(0, 3)];
        end
        default: op = ops[int'(k)];
      endcase
      run_instr(k, op, f3, rb(), $urandom_range(0, 2), $urandom_range(0, 3), rb());
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
